// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: channel mode encodings and the
// per-channel ramp phase-offset helper.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF    = 2'b00,
    LED_MODE_ON     = 2'b01,
    LED_MODE_BREATH = 2'b10,
    LED_MODE_BLINK  = 2'b11
  } led_mode_e;

  // Spreads the channel ramps evenly over one ramp span: (k * 2^ramp_w) / n_ch.
  function automatic logic [63:0] phase_offset(input int unsigned k,
                                               input int unsigned ramp_w,
                                               input int unsigned n_ch);
    return (64'(k) << ramp_w) / 64'(n_ch);
  endfunction

endpackage

// File: rtl/led_ramp_gen.sv
// Free-running triangle counter 0..MAX..0 with a direction flag; the flag
// flips on the same edge the counter lands on an endpoint, so no value repeats.
module led_ramp_gen #(
  parameter int                RAMP_W = 21,
  parameter logic [RAMP_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [RAMP_W-1:0] ramp,
  output logic              dir_up
);

  localparam logic [RAMP_W-1:0] ONE      = RAMP_W'(1);
  localparam logic [RAMP_W-1:0] LAST_UP  = {RAMP_W{1'b1}} - ONE;

  logic [RAMP_W-1:0] ramp_reg;
  logic              dir_up_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ramp_reg   <= INIT;
      dir_up_reg <= 1'b1;
    end else if (dir_up_reg) begin
      ramp_reg <= ramp_reg + ONE;
      if (ramp_reg == LAST_UP) dir_up_reg <= 1'b0;
    end else begin
      ramp_reg <= ramp_reg - ONE;
      if (ramp_reg == ONE) dir_up_reg <= 1'b1;
    end
  end

  assign ramp   = ramp_reg;
  assign dir_up = dir_up_reg;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel active-low LED PWM driver (OFF / ON / BREATH / BLINK per channel).
// Define LED_GAMMA_EN to square the BREATH duty (adds one pipeline stage on that path).
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int PWM_W  = 8,
  parameter int RAMP_W = 21
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [2*N_CH-1:0]       i_mode,
  input  logic [PWM_W*N_CH-1:0]   i_level,
  output logic [N_CH-1:0]         o_led,
  output logic                    o_period_start
);

  localparam logic [PWM_W-1:0] DUTY_FULL = {PWM_W{1'b1}};

  logic [PWM_W-1:0] cnt_reg;
  logic             period_start_reg;
  logic [N_CH-1:0]  led_reg;
  logic [N_CH-1:0]  lit;
  logic             wrap;

  // Shadow registers load on the same edge the counter rolls over.
  assign wrap = (cnt_reg == DUTY_FULL);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_reg + PWM_W'(1);
      period_start_reg <= wrap;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      led_mode_e         mode_sh_reg;
      logic [PWM_W-1:0]  level_sh_reg;
      logic [RAMP_W-1:0] ramp;
      logic              dir_up;
      logic [PWM_W-1:0]  breath_lin;
      logic [PWM_W-1:0]  breath_duty;
      logic [PWM_W-1:0]  duty;
      logic              force_lit;

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          mode_sh_reg  <= LED_MODE_OFF;
          level_sh_reg <= '0;
        end else if (wrap) begin
          mode_sh_reg  <= led_mode_e'(i_mode[2*gi +: 2]);
          level_sh_reg <= i_level[PWM_W*gi +: PWM_W];
        end
      end

      led_ramp_gen #(
        .RAMP_W (RAMP_W),
        .INIT   (RAMP_W'(phase_offset(gi, RAMP_W, N_CH)))
      ) u_ramp (
        .clk    (i_clk),
        .rstn   (i_rstn),
        .ramp   (ramp),
        .dir_up (dir_up)
      );

      assign breath_lin = PWM_W'(ramp >> (RAMP_W - PWM_W));

`ifdef LED_GAMMA_EN
      logic [2*PWM_W-1:0] breath_sq;
      logic [PWM_W-1:0]   breath_duty_reg;

      assign breath_sq = {{PWM_W{1'b0}}, breath_lin} * {{PWM_W{1'b0}}, breath_lin};

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) breath_duty_reg <= '0;
        else         breath_duty_reg <= breath_sq[2*PWM_W-1 -: PWM_W];
      end

      assign breath_duty = breath_duty_reg;
`else
      assign breath_duty = breath_lin;
`endif

      always_comb begin
        duty = '0;
        case (mode_sh_reg)
          LED_MODE_OFF:    duty = '0;
          LED_MODE_ON:     duty = level_sh_reg;
          LED_MODE_BREATH: duty = breath_duty;
          LED_MODE_BLINK:  duty = dir_up ? DUTY_FULL : '0;
          default:         duty = '0;
        endcase
      end

      // A full-scale fixed duty must not leave a dark cycle at cnt = all-ones.
      assign force_lit = ((mode_sh_reg == LED_MODE_ON) || (mode_sh_reg == LED_MODE_BLINK))
                         && (duty == DUTY_FULL);
      assign lit[gi]   = force_lit || (cnt_reg < duty);
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) led_reg <= '1;
    else         led_reg <= ~lit;
  end

  assign o_led          = led_reg;
  assign o_period_start = period_start_reg;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank (N_CH=4, PWM_W=4, RAMP_W=8); the reference
// model derives every output from the edge count since reset and the channel rules.
module tb_led_pwm_bank;

  localparam int N_CH   = 4;
  localparam int PWM_W  = 4;
  localparam int RAMP_W = 8;
  localparam int PER    = 16;
  localparam int RMAX   = 255;
  localparam int TRI    = 510;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [2*N_CH-1:0]     mode = '0;
  logic [PWM_W*N_CH-1:0] level = '0;
  logic [N_CH-1:0]       led;
  logic                  ps;

  always #5 clk = ~clk;

  led_pwm_bank #(.N_CH(N_CH), .PWM_W(PWM_W), .RAMP_W(RAMP_W)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_mode         (mode),
    .i_level        (level),
    .o_led          (led),
    .o_period_start (ps)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         n_edge;
  logic [1:0] sh_mode [N_CH];
  int         sh_lvl  [N_CH];
  int         gam     [N_CH];
  logic [N_CH-1:0] exp_led;
  logic            exp_ps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, n_edge);
    end
  endtask

  function automatic void model_reset();
    n_edge = 0;
    for (int k = 0; k < N_CH; k++) begin
      sh_mode[k] = 2'b00;
      sh_lvl[k]  = 0;
      gam[k]     = 0;
    end
  endfunction

  // Triangle position of channel k, m cycles after reset: seeded at k*64, going up.
  function automatic int tri_pos(input int k, input int m);
    return (k * (256 / N_CH) + m) % TRI;
  endfunction

  task automatic tick();
    int cnt;
    cnt = n_edge % PER;
    for (int k = 0; k < N_CH; k++) begin
      int p, v, r, duty;
      bit up, lit;
      p  = tri_pos(k, n_edge);
      v  = (p <= RMAX) ? p : TRI - p;
      up = (p < RMAX);
      r  = v / 16;
      case (sh_mode[k])
        2'b01:   duty = sh_lvl[k];
`ifdef LED_GAMMA_EN
        2'b10:   duty = gam[k];
`else
        2'b10:   duty = r;
`endif
        2'b11:   duty = up ? 15 : 0;
        default: duty = 0;
      endcase
      lit = (cnt < duty) || (duty == 15 && (sh_mode[k] == 2'b01 || sh_mode[k] == 2'b11));
      exp_led[k] = !lit;
      gam[k] = (r * r) / 16;
    end
    exp_ps = (cnt == PER - 1);
    if (cnt == PER - 1) begin
      for (int k = 0; k < N_CH; k++) begin
        sh_mode[k] = mode[2*k +: 2];
        sh_lvl[k]  = int'(level[PWM_W*k +: PWM_W]);
      end
    end
    n_edge++;
    @(posedge clk); #1;
    check("led", 32'(led), 32'(exp_led));
    check("period_start", 32'(ps), 32'(exp_ps));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zeros;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'hF);
    check("reset_period_start", 32'(ps), 32'h0);
    rstn = 1'b1;

    // All OFF: dark, first period_start 16 edges after release.
    repeat (20) tick();

    // ch0 ON level 4, then level 15.
    mode  = 8'b00_00_00_01;
    level = 16'h0004;
    repeat (32) tick();
    zeros = 0;
    repeat (16) begin tick(); zeros += int'(!led[0]); end
    check("on_level4_lit_cycles", 32'(zeros), 32'd4);
    level = 16'h000F;
    repeat (32) tick();
    zeros = 0;
    repeat (16) begin tick(); zeros += int'(!led[0]); end
    check("on_level15_lit_cycles", 32'(zeros), 32'd16);

    // Level change mid-period (cnt = 7) waits for the next shadow load.
    level = 16'h0004;
    repeat (32) tick();
    while (n_edge % PER != 7) tick();
    level = 16'h000C;
    zeros = 0;
    repeat (9) begin tick(); zeros += int'(!led[0]); end
    check("midperiod_old_duty", 32'(zeros), 32'd0);
    zeros = 0;
    repeat (16) begin tick(); zeros += int'(!led[0]); end
    check("next_period_new_duty", 32'(zeros), 32'd12);

    // All BREATH across a full triangle.
    mode = 8'b10_10_10_10;
    repeat (600) tick();

    // ch2 BLINK: half the triangle lit, half dark.
    mode = 8'b10_11_10_10;
    repeat (32) tick();
    zeros = 0;
    repeat (TRI) begin tick(); zeros += int'(!led[2]); end
    check("blink_lit_cycles", 32'(zeros), 32'd255);

    // Randomised mode/level changes at arbitrary points in the period.
    repeat (60) begin
      mode  = 8'($urandom);
      level = 16'($urandom);
      repeat ($urandom_range(3, 40)) tick();
    end

    // Asynchronous reset in the middle of a BREATH period.
    mode = 8'b10_10_10_10;
    repeat (103) tick();
    #2 rstn = 1'b0;
    #1;
    check("midreset_led", 32'(led), 32'hF);
    check("midreset_period_start", 32'(ps), 32'h0);
    @(posedge clk); #1;
    check("held_reset_led", 32'(led), 32'hF);
    rstn = 1'b1;
    model_reset();
    repeat (300) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
